// File: rtl/fetch_queue_stage_if.sv
// Instruction-memory request/response bundle for fetch_queue_stage.
// master: fetch stage (drives request), slave: instruction memory (drives response).
interface fetch_queue_stage_if #(
    parameter int WIDTH = 32
) ();
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue of {instr, pc, pc+4}.
// Requests are credit-limited so every in-flight response has a free slot.
// A redirect empties the queue and marks all in-flight responses for dropping.
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response arriving
// at an empty queue is forwarded combinationally to the decode outputs.
module fetch_queue_stage #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] PC_INIT = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PCSrcE,
    input  logic [WIDTH-1:0]    PCTargetE,
    input  logic                StallF,
    input  logic                StallD,
    input  logic                FlushD,
    fetch_queue_stage_if.master imem,
    output logic [WIDTH-1:0]    InstrD,
    output logic [WIDTH-1:0]    PCD,
    output logic [WIDTH-1:0]    PCPlus4D,
    output logic                ValidD
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'(DEPTH);
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(4);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] resp_pc;      // address of the next response that will be kept
    logic [WIDTH-1:0] q_instr [DEPTH];
    logic [WIDTH-1:0] q_pc    [DEPTH];
    logic [WIDTH-1:0] q_pc4   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;

    logic credit_ok;
    logic accept;
    logic resp_fire;
    logic resp_keep;
    logic q_empty;
    logic q_push;
    logic q_pop;
    logic bypass_hit;
    logic bypass_take;

    assign q_empty   = (count == '0);
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < CREDIT_MAX;

    // Reset gates the request so nothing is issued while rst is low.
    assign imem.imem_req  = rst && !StallF && !PCSrcE && credit_ok;
    assign imem.imem_addr = pc;
    assign accept         = imem.imem_req && imem.imem_ready;

    // A response with nothing outstanding belongs to a pre-reset request: ignore it.
    assign resp_fire = imem.imem_rvalid && (outstanding != '0);
    assign resp_keep = resp_fire && (drop == '0) && !PCSrcE;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit  = q_empty && resp_keep;
    assign bypass_take = bypass_hit && (!StallD || FlushD);
`else
    assign bypass_hit  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign q_push = resp_keep && !bypass_take;
    assign q_pop  = !q_empty && (FlushD || !StallD);

    // Control state: PC, response tracker, credit counters and queue pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= PC_INIT;
            resp_pc     <= PC_INIT;
            outstanding <= '0;
            drop        <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            if (PCSrcE) begin
                pc <= PCTargetE;
            end else if (accept) begin
                pc <= pc + STEP;
            end

            // Requests between redirects are sequential, so the kept-response
            // address is just a second PC that restarts at each redirect target.
            if (PCSrcE) begin
                resp_pc <= PCTargetE;
            end else if (resp_keep) begin
                resp_pc <= resp_pc + STEP;
            end

            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(resp_fire);

            if (PCSrcE) begin
                drop <= outstanding - CNT_W'(resp_fire);
            end else if (resp_fire && (drop != '0)) begin
                drop <= drop - CNT_W'(1);
            end

            if (PCSrcE) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (q_push) begin
                    tail <= tail + PTR_W'(1);
                end
                if (q_pop) begin
                    head <= head + PTR_W'(1);
                end
                count <= count + CNT_W'(q_push) - CNT_W'(q_pop);
            end
        end
    end

    // Queue storage; contents are only visible through a valid head, so no reset.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_instr[tail] <= imem.imem_rdata;
            q_pc[tail]    <= resp_pc;
            q_pc4[tail]   <= resp_pc + STEP;
        end
    end

    // Decode-facing head: queue head, bypassed response, or an all-zero bubble.
    always_comb begin
        ValidD   = 1'b0;
        InstrD   = '0;
        PCD      = '0;
        PCPlus4D = '0;
        if (!q_empty) begin
            ValidD   = 1'b1;
            InstrD   = q_instr[head];
            PCD      = q_pc[head];
            PCPlus4D = q_pc4[head];
        end else if (bypass_hit) begin
            ValidD   = 1'b1;
            InstrD   = imem.imem_rdata;
            PCD      = resp_pc;
            PCPlus4D = resp_pc + STEP;
        end
    end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage (default build): in-order memory model with
// programmable latency, expected-entry queue filled at request acceptance,
// a per-cycle vector table after reset, and hand sequences for redirect,
// flush, PC wrap and reset with requests in flight.
module tb_fetch_queue_stage;
    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_queue_stage_if #(.WIDTH(WIDTH)) bus ();

    fetch_queue_stage #(.WIDTH(WIDTH), .DEPTH(4), .PC_INIT(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .imem      (bus),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        stall_d;
        logic        exp_valid;
        logic [31:0] exp_pcd;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    sb_t         sb[$];
    pend_t       pend[$];
    vec_t        vt[12];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] exp_pc = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_3C3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mem_drive();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = instr_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
    endtask

    task automatic observe();
        sb_t e;
        if (bus.imem_req && bus.imem_ready) begin
            pend.push_back('{addr: bus.imem_addr, due: cyc + lat});
        end
        if (!rst) return;
        if (!ValidD) begin
            check("bubble_instr", InstrD, 32'h0);
            check("bubble_pcd", PCD, 32'h0);
            check("bubble_pc4", PCPlus4D, 32'h0);
        end
        if (PCSrcE) begin
            check("req_in_redirect", bus.imem_req, 1'b0);
            sb.delete();
            exp_pc = PCTargetE;
        end else begin
            if (ValidD && (FlushD || !StallD)) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_empty: got head PCD %h want no entry (cycle %0d)", PCD, cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_pcd", PCD, e.pc);
                    check("sb_instr", InstrD, e.instr);
                    check("sb_pc4", PCPlus4D, e.pc + 32'd4);
                end
            end
            if (bus.imem_req && bus.imem_ready) begin
                check("req_addr", bus.imem_addr, exp_pc);
                sb.push_back('{pc: exp_pc, instr: instr_of(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic to_neg();
        mem_drive();
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        to_neg();
        finish_cycle();
    endtask

    task automatic do_reset(input bit drain);
        rst = 1'b0;
        #1;
        check("rst_valid", ValidD, 1'b0);
        check("rst_instr", InstrD, 32'h0);
        check("rst_pcd", PCD, 32'h0);
        check("rst_pc4", PCPlus4D, 32'h0);
        check("rst_req", bus.imem_req, 1'b0);
        sb.delete();
        exp_pc = 32'h0;
        cycle();
        if (drain) begin
            for (int k = 0; k < 20 && pend.size() > 0; k++) cycle();
        end
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;

        //            stall_d valid  pcd     req   addr
        vt[0]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        vt[1]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
        vt[2]  = '{1'b1, 1'b1, 32'h00, 1'b1, 32'h08};
        vt[3]  = '{1'b1, 1'b1, 32'h00, 1'b1, 32'h0C};
        vt[4]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h10};
        vt[5]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h10};
        vt[6]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h10};
        vt[7]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h10};
        vt[8]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h14};
        vt[9]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h18};
        vt[10] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h1C};
        vt[11] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h20};

        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        @(posedge clk);
        #1;

        // Fill with StallD held (credit limit at 4), then drain in order.
        lat = 1;
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            StallD = vt[i].stall_d;
            to_neg();
            check($sformatf("t%0d_valid", i), ValidD, vt[i].exp_valid);
            check($sformatf("t%0d_pcd", i), PCD, vt[i].exp_pcd);
            check($sformatf("t%0d_pc4", i), PCPlus4D, vt[i].exp_valid ? vt[i].exp_pcd + 32'd4 : 32'h0);
            check($sformatf("t%0d_instr", i), InstrD, vt[i].exp_valid ? instr_of(vt[i].exp_pcd) : 32'h0);
            check($sformatf("t%0d_req", i), bus.imem_req, vt[i].exp_req);
            check($sformatf("t%0d_addr", i), bus.imem_addr, vt[i].exp_addr);
            finish_cycle();
        end

        // Redirect with two requests in flight at 3-cycle latency.
        lat = 3;
        StallD = 1'b0;
        do_reset(1'b1);
        cycle();
        cycle();
        PCSrcE = 1'b1;
        PCTargetE = 32'h100;
        cycle();
        PCSrcE = 1'b0;
        to_neg();
        check("rd_addr", bus.imem_addr, 32'h100);
        check("rd_req", bus.imem_req, 1'b1);
        check("rd_valid0", ValidD, 1'b0);
        finish_cycle();
        n = 1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            to_neg();
            if (ValidD) begin
                found = 1'b1;
                break;
            end
            finish_cycle();
            n++;
        end
        check("rd_found", found, 1'b1);
        check("rd_latency", n, 4);
        check("rd_pcd", PCD, 32'h100);
        check("rd_pc4", PCPlus4D, 32'h104);
        finish_cycle();
        repeat (10) cycle();

        // FlushD with three entries queued, head at 0x8.
        lat = 1;
        do_reset(1'b1);
        repeat (4) cycle();
        StallD = 1'b1;
        cycle();
        StallF = 1'b1;
        cycle();
        FlushD = 1'b1;
        to_neg();
        check("fl_valid", ValidD, 1'b1);
        check("fl_head", PCD, 32'h8);
        finish_cycle();
        FlushD = 1'b0;
        to_neg();
        check("fl_next", PCD, 32'hC);
        check("fl_pc", bus.imem_addr, 32'h14);
        finish_cycle();
        StallF = 1'b0;
        StallD = 1'b0;
        repeat (10) cycle();

        // PC wrap through redirect to 0xFFFFFFF8.
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFF8;
        cycle();
        PCSrcE = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            to_neg();
            if (ValidD && PCD == 32'hFFFF_FFFC) begin
                found = 1'b1;
                check("wrap_pc4", PCPlus4D, 32'h0);
            end
            finish_cycle();
        end
        check("wrap_found", found, 1'b1);

        // Reset asserted with two requests outstanding; late responses ignored.
        lat = 2;
        do_reset(1'b1);
        cycle();
        cycle();
        cycle();
        check("pre_rst_valid", ValidD, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", ValidD, 1'b0);
        check("mid_rst_instr", InstrD, 32'h0);
        check("mid_rst_pcd", PCD, 32'h0);
        check("mid_rst_pc4", PCPlus4D, 32'h0);
        check("mid_rst_req", bus.imem_req, 1'b0);
        check("mid_rst_addr", bus.imem_addr, 32'h0);
        sb.delete();
        exp_pc = 32'h0;
        cycle();
        rst = 1'b1;
        StallF = 1'b1;
        for (int k = 0; k < 4; k++) begin
            to_neg();
            check($sformatf("late_valid%0d", k), ValidD, 1'b0);
            finish_cycle();
        end
        StallF = 1'b0;
        to_neg();
        check("restart_addr", bus.imem_addr, 32'h0);
        check("restart_req", bus.imem_req, 1'b1);
        finish_cycle();
        repeat (10) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
